// File: rtl/vga_box_renderer.sv
// vga_box_renderer
//
// Pixel-generation stage that sits directly after the 640x480 VGA sync
// generator. It draws a solid box over a flat background. Once per frame, at
// the start of vertical blanking, the box moves STEP pixels on each axis and
// bounces off the screen edges. Colour and the delayed syncs leave on the
// same two-stage pixel-tick pipeline, so they stay aligned.
//
// Optional feature: define VGA_BORDER_EN to draw a BORDER_W-thick frame in
// BORDER_COLOR around the active area. The frame takes priority over the box
// and narrows the box's motion limits so the box stays inside it.
//
// Ports:
//   clk       system clock, shared with the sync generator
//   reset     asynchronous, active-low reset
//   p_tick    pixel enable strobe from the sync generator
//   video_on  active-area flag
//   hsync_in  horizontal sync from the sync generator
//   vsync_in  vertical sync from the sync generator
//   pixel_x   current column
//   pixel_y   current line
//   pause     level input; freezes box motion while high
//   rgb       pixel colour, RGB 3-3-2, two pixel ticks after its inputs
//   hsync     hsync_in delayed to align with rgb
//   vsync     vsync_in delayed to align with rgb
//   box_x     current box left edge
//   box_y     current box top edge

module vga_box_renderer #(
  parameter int          HD           = 640,
  parameter int          VD           = 480,
  parameter int          BOX_W        = 32,
  parameter int          BOX_H        = 32,
  parameter int          STEP         = 2,
  parameter int          X0           = 304,
  parameter int          Y0           = 224,
  parameter logic [7:0]  BOX_COLOR    = 8'hE0,
  parameter logic [7:0]  BG_COLOR     = 8'h03,
  parameter int          BORDER_W     = 8,
  parameter logic [7:0]  BORDER_COLOR = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       p_tick,
  input  logic       video_on,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       pause,
  output logic [7:0] rgb,
  output logic       hsync,
  output logic       vsync,
  output logic [9:0] box_x,
  output logic [9:0] box_y
);

  // Motion limits. All position arithmetic is 11 bits wide so that adding
  // STEP or BOX_W to a 10-bit coordinate can never wrap.
`ifdef VGA_BORDER_EN
  localparam logic [10:0] XMIN = 11'(BORDER_W);
  localparam logic [10:0] YMIN = 11'(BORDER_W);
  localparam logic [10:0] XMAX = 11'(HD - BORDER_W - BOX_W);
  localparam logic [10:0] YMAX = 11'(VD - BORDER_W - BOX_H);
`else
  localparam logic [10:0] XMIN = 11'd0;
  localparam logic [10:0] YMIN = 11'd0;
  localparam logic [10:0] XMAX = 11'(HD - BOX_W);
  localparam logic [10:0] YMAX = 11'(VD - BOX_H);
`endif
  localparam logic [10:0] STEP_W = 11'(STEP);
  localparam logic [10:0] BOX_W_W = 11'(BOX_W);
  localparam logic [10:0] BOX_H_W = 11'(BOX_H);

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_UPD_X = 2'd1,
    ST_UPD_Y = 2'd2
  } state_t;

  state_t state, state_next;
  logic   upd_x, upd_y;
  logic   frame_tick;

  // Start of vertical blanking: the first pixel of the first blank line.
  assign frame_tick = p_tick && (pixel_x == 10'd0) && (pixel_y == 10'(VD));

  // ---------------------------------------------------------------------
  // Motion FSM: state register / next state / outputs
  // ---------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_WAIT;
    else        state <= state_next;
  end

  // NOTE: every combinational output gets a default first; a path that
  // leaves a signal unassigned would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_WAIT:  if (frame_tick && !pause) state_next = ST_UPD_X;
      ST_UPD_X: state_next = ST_UPD_Y;
      ST_UPD_Y: state_next = ST_WAIT;
      default:  state_next = ST_WAIT;
    endcase
  end

  always_comb begin
    upd_x = 1'b0;
    upd_y = 1'b0;
    unique case (state)
      ST_UPD_X: upd_x = 1'b1;
      ST_UPD_Y: upd_y = 1'b1;
      default:  ;
    endcase
  end

  // ---------------------------------------------------------------------
  // Box position and direction (dir = 1 means right / down)
  // ---------------------------------------------------------------------
  logic        dir_x, dir_y;
  logic [10:0] pos_x, pos_y;
  logic [10:0] fwd_x, fwd_y;
  logic [9:0]  box_x_next, box_y_next;
  logic        dir_x_next, dir_y_next;

  assign pos_x = {1'b0, box_x};
  assign pos_y = {1'b0, box_y};
  assign fwd_x = pos_x + STEP_W;
  assign fwd_y = pos_y + STEP_W;

  // A step that would reach or pass a limit lands exactly on the limit and
  // reverses direction, so the box never leaves the allowed range.
  always_comb begin
    box_x_next = box_x;
    dir_x_next = dir_x;
    if (dir_x) begin
      if (fwd_x >= XMAX) begin
        box_x_next = XMAX[9:0];
        dir_x_next = 1'b0;
      end else begin
        box_x_next = fwd_x[9:0];
      end
    end else begin
      if (pos_x <= XMIN + STEP_W) begin
        box_x_next = XMIN[9:0];
        dir_x_next = 1'b1;
      end else begin
        box_x_next = box_x - STEP_W[9:0];
      end
    end
  end

  always_comb begin
    box_y_next = box_y;
    dir_y_next = dir_y;
    if (dir_y) begin
      if (fwd_y >= YMAX) begin
        box_y_next = YMAX[9:0];
        dir_y_next = 1'b0;
      end else begin
        box_y_next = fwd_y[9:0];
      end
    end else begin
      if (pos_y <= YMIN + STEP_W) begin
        box_y_next = YMIN[9:0];
        dir_y_next = 1'b1;
      end else begin
        box_y_next = box_y - STEP_W[9:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      box_x <= 10'(X0);
      box_y <= 10'(Y0);
      dir_x <= 1'b1;
      dir_y <= 1'b1;
    end else begin
      if (upd_x) begin
        box_x <= box_x_next;
        dir_x <= dir_x_next;
      end
      if (upd_y) begin
        box_y <= box_y_next;
        dir_y <= dir_y_next;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Render pipeline, advancing only on p_tick
  // ---------------------------------------------------------------------
  logic [10:0] px, py;
  logic        in_box;
  logic        in_box_d, video_on_d, hsync_d, vsync_d;

  assign px = {1'b0, pixel_x};
  assign py = {1'b0, pixel_y};
  assign in_box = (px >= pos_x) && (px < pos_x + BOX_W_W) &&
                  (py >= pos_y) && (py < pos_y + BOX_H_W);

`ifdef VGA_BORDER_EN
  logic in_border, in_border_d;
  assign in_border = (px < 11'(BORDER_W)) || (px >= 11'(HD - BORDER_W)) ||
                     (py < 11'(BORDER_W)) || (py >= 11'(VD - BORDER_W));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      in_border_d <= 1'b0;
    else if (p_tick) in_border_d <= in_border;
  end
`endif

  // NOTE: only flops are reset here; the design has no memories, so every
  // pipeline register clears on reset and no stale colour can escape.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_box_d   <= 1'b0;
      video_on_d <= 1'b0;
      hsync_d    <= 1'b0;
      vsync_d    <= 1'b0;
    end else if (p_tick) begin
      in_box_d   <= in_box;
      video_on_d <= video_on;
      hsync_d    <= hsync_in;
      vsync_d    <= vsync_in;
    end
  end

  logic [7:0] colour;

  always_comb begin
    colour = 8'h00;
    if (video_on_d) begin
`ifdef VGA_BORDER_EN
      if (in_border_d)   colour = BORDER_COLOR;
      else if (in_box_d) colour = BOX_COLOR;
      else               colour = BG_COLOR;
`else
      if (in_box_d) colour = BOX_COLOR;
      else          colour = BG_COLOR;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rgb   <= 8'h00;
      hsync <= 1'b0;
      vsync <= 1'b0;
    end else if (p_tick) begin
      rgb   <= colour;
      hsync <= hsync_d;
      vsync <= vsync_d;
    end
  end

endmodule

// File: tb/tb_vga_box_renderer.sv
// Self-checking bench for vga_box_renderer. A behavioural model predicts the
// box position from the number of accepted frame ticks (a reflected ramp
// between the motion limits) and the colour/syncs from pixel-level rules
// delayed by two pixel ticks; a compare process checks every cycle. Directed
// literal checks pin the model at the interesting points.

module tb_vga_box_renderer;

  localparam int VD = 480;

`ifdef VGA_BORDER_EN
  localparam int XLO = 8,  XHI = 600, YLO = 8, YHI = 440;
  localparam int X_HIT_F = 148, X_LO_F = 444, Y_HIT_F = 108;
  localparam int X_HIT = 600, Y_HIT = 440, X_LO = 8;
`else
  localparam int XLO = 0,  XHI = 608, YLO = 0, YHI = 448;
  localparam int X_HIT_F = 152, X_LO_F = 456, Y_HIT_F = 112;
  localparam int X_HIT = 608, Y_HIT = 448, X_LO = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       p_tick = 1'b0;
  logic       video_on = 1'b0;
  logic       hsync_in = 1'b0;
  logic       vsync_in = 1'b0;
  logic [9:0] pixel_x = '0;
  logic [9:0] pixel_y = '0;
  logic       pause = 1'b0;
  logic [7:0] rgb;
  logic       hsync, vsync;
  logic [9:0] box_x, box_y;

  int checks = 0;
  int errors = 0;

  vga_box_renderer dut (
    .clk(clk), .reset(reset), .p_tick(p_tick), .video_on(video_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .pixel_x(pixel_x),
    .pixel_y(pixel_y), .pause(pause), .rgb(rgb), .hsync(hsync),
    .vsync(vsync), .box_x(box_x), .box_y(box_y)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Position after n moves: the box walks STEP per frame along a line that
  // folds back at the limits (all distances are multiples of STEP).
  function automatic int bounce(input int n, input int p0, input int lo,
                                input int hi);
    int span, u;
    span = hi - lo;
    u = (p0 - lo + 2 * n) % (2 * span);
    return (u <= span) ? lo + u : lo + 2 * span - u;
  endfunction

  function automatic logic [7:0] pix_colour(input int x, input int y,
                                            input logic von, input int bx,
                                            input int by);
    if (!von) return 8'h00;
`ifdef VGA_BORDER_EN
    if (x < 8 || x >= 632 || y < 8 || y >= 472) return 8'hFF;
`endif
    if (x >= bx && x < bx + 32 && y >= by && y < by + 32) return 8'hE0;
    return 8'h03;
  endfunction

  logic [9:0] m_stage = '0;   // {rgb, hsync, vsync} sampled one tick ago
  logic [9:0] m_out   = '0;   // what the outputs must show now
  int         m_fx = 0, m_fy = 0, m_phase = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_stage = '0; m_out = '0; m_fx = 0; m_fy = 0; m_phase = 0;
    end else begin
      if (p_tick) begin
        m_out = m_stage;
        m_stage = {pix_colour(int'(pixel_x), int'(pixel_y), video_on,
                              bounce(m_fx, 304, XLO, XHI),
                              bounce(m_fy, 224, YLO, YHI)),
                   hsync_in, vsync_in};
      end
      if (m_phase == 1) begin
        m_fx++; m_phase = 2;
      end else if (m_phase == 2) begin
        m_fy++; m_phase = 0;
      end else if (p_tick && pixel_x == 10'd0 && pixel_y == 10'(VD) && !pause)
        m_phase = 1;
    end
  end

  always @(negedge clk) begin
    check("rgb_model",   32'(rgb),   32'(m_out[9:2]));
    check("hsync_model", 32'(hsync), 32'(m_out[1]));
    check("vsync_model", 32'(vsync), 32'(m_out[0]));
    check("box_x_model", 32'(box_x), 32'(bounce(m_fx, 304, XLO, XHI)));
    check("box_y_model", 32'(box_y), 32'(bounce(m_fy, 224, YLO, YHI)));
  end

  // ---------------- stimulus ----------------
  task automatic pix(input int x, input int y, input logic von,
                     input logic hs, input logic vs);
    @(posedge clk); #1;
    pixel_x = 10'(x); pixel_y = 10'(y);
    video_on = von; hsync_in = hs; vsync_in = vs; p_tick = 1'b1;
    @(posedge clk); #1;
    p_tick = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic frame();
    @(posedge clk); #1;
    pixel_x = 10'd0; pixel_y = 10'(VD); video_on = 1'b0; p_tick = 1'b1;
    @(posedge clk); #1;
    p_tick = 1'b0; pixel_y = 10'd0;
    repeat (3) @(posedge clk);
  endtask

  int nfr;

  initial begin
    // Reset held from time zero.
    repeat (3) @(negedge clk);
    check("rst_rgb",   32'(rgb),   32'h0);
    check("rst_hsync", 32'(hsync), 32'h0);
    check("rst_box_x", 32'(box_x), 32'd304);
    check("rst_box_y", 32'(box_y), 32'd224);
    @(posedge clk); #2 reset = 1'b1;

    // Colour path: box pixel, background pixel, blanking.
    pix(310, 230, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check("lat_not_yet", 32'(rgb), 32'h00);
    pix(100, 100, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    check("box_colour", 32'(rgb),   32'hE0);
    check("hsync_lat",  32'(hsync), 32'h1);
    pix(0, 0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("bg_colour", 32'(rgb),   32'h03);
    check("vsync_lat", 32'(vsync), 32'h1);
    pix(0, 0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("blank_colour", 32'(rgb), 32'h00);

    // Outputs hold while p_tick stays low.
    pix(100, 100, 1'b1, 1'b0, 1'b0);
    pix(100, 100, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    pixel_x = 10'd310; pixel_y = 10'd230; video_on = 1'b0; hsync_in = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("hold_rgb",   32'(rgb),   32'h03);
    check("hold_hsync", 32'(hsync), 32'h0);

    // hsync_in toggling every pixel tick.
    for (int i = 0; i < 8; i++) pix(i, 5, 1'b1, 1'(i % 2), 1'b0);
    @(negedge clk);
    check("hs_toggle", 32'(hsync), 32'h0);

`ifdef VGA_BORDER_EN
    pix(3, 200, 1'b1, 1'b0, 1'b0);
    pix(3, 200, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("border_colour", 32'(rgb), 32'hFF);
`endif

    // Reset mid-line clears the pipeline immediately.
    pix(310, 230, 1'b1, 1'b1, 1'b1);
    pix(310, 230, 1'b1, 1'b1, 1'b1);
    @(posedge clk); #3 reset = 1'b0;
    #1;
    check("midrst_rgb",   32'(rgb),   32'h0);
    check("midrst_hsync", 32'(hsync), 32'h0);
    check("midrst_vsync", 32'(vsync), 32'h0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    pix(310, 230, 1'b1, 1'b0, 1'b0);
    pix(0, 0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("post_rst_colour", 32'(rgb), 32'hE0);

    // First frame tick, cycle by cycle.
    @(posedge clk); #1;
    pixel_x = 10'd0; pixel_y = 10'(VD); video_on = 1'b0; p_tick = 1'b1;
    @(posedge clk); #1;
    p_tick = 1'b0; pixel_y = 10'd0;
    check("f1_x_tick", 32'(box_x), 32'd304);
    @(posedge clk); #1;
    check("f1_x", 32'(box_x), 32'd306);
    check("f1_y_early", 32'(box_y), 32'd224);
    @(posedge clk); #1;
    check("f1_y", 32'(box_y), 32'd226);
    nfr = 1;

    // Paused frames change nothing.
    pause = 1'b1;
    repeat (3) frame();
    @(negedge clk);
    check("pause_x", 32'(box_x), 32'd306);
    check("pause_y", 32'(box_y), 32'd226);
    pause = 1'b0;

    // Run to both bottom-edge and right/left-edge bounces.
    while (nfr <= X_LO_F) begin
      frame();
      nfr++;
      if (nfr == Y_HIT_F - 1) check("y_before", 32'(box_y), 32'(Y_HIT - 2));
      if (nfr == Y_HIT_F)     check("y_hit",    32'(box_y), 32'(Y_HIT));
      if (nfr == Y_HIT_F + 1) check("y_back",   32'(box_y), 32'(Y_HIT - 2));
      if (nfr == X_HIT_F - 2) check("x_m2",     32'(box_x), 32'(X_HIT - 4));
      if (nfr == X_HIT_F - 1) check("x_m1",     32'(box_x), 32'(X_HIT - 2));
      if (nfr == X_HIT_F)     check("x_hit",    32'(box_x), 32'(X_HIT));
      if (nfr == X_HIT_F + 1) check("x_back",   32'(box_x), 32'(X_HIT - 2));
      if (nfr == X_LO_F)      check("x_lo",     32'(box_x), 32'(X_LO));
      if (nfr == X_LO_F + 1)  check("x_lo_back", 32'(box_x), 32'(X_LO + 2));
    end

    repeat (4) @(posedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
